popcount_stream: RTL

POPCOUNT_STREAM -- requirements
Module: popcount_stream

---
 rtl/popcount_stream_pkg.sv | 26 ++
 rtl/popcount_stream_seg.sv | 23 ++
 rtl/popcount_stream.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/popcount_stream_pkg.sv
// popcount_pkg
// Shared defaults for the popcount stream block and a constant clog2 helper
// used to size the count fields at elaboration time.
//   DEF_DATA_W : default input word width
//   DEF_SEG_W  : default first-stage segment width
//   DEF_ACC_W  : default accumulator / output width
//   clog2(v)   : ceil(log2(v)), returns 0 for v <= 1
package popcount_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_SEG_W  = 16;
    localparam int DEF_ACC_W  = 16;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/popcount_stream_seg.sv
// seg_popcount
// Combinational population count of one SEG_W-bit segment.
// Ports:
//   seg : segment to count (already inverted by the caller for zero counting)
//   cnt : number of set bits, 0..SEG_W
module seg_popcount
    import popcount_pkg::*;
#(
    parameter  int SEG_W = DEF_SEG_W,
    localparam int OUT_W = clog2(SEG_W + 1)
) (
    input  logic [SEG_W-1:0] seg,
    output logic [OUT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < SEG_W; i++) begin
            cnt = cnt + OUT_W'(seg[i]);
        end
    end

endmodule

// File: rtl/popcount_stream.sv
// popcount_stream
// Three-stage streaming population counter with optional packet accumulation.
// Stage 1 registers per-segment counts, stage 2 the beat count, stage 3 the
// result and the packet accumulator. A beat sampled at edge t produces its
// result at edge t+2. No backpressure: one beat per cycle.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : beat qualifier
//   in_data   : word to count
//   in_mode   : 0 counts ones, 1 counts zeros
//   in_acc    : 1 adds the beat to the open packet, 0 emits it standalone
//   in_last   : with in_acc=1, closes the packet
//   out_valid : one-cycle result strobe
//   out_data  : result, zero-extended; 0 while out_valid=0
//   out_sat   : packet saturated; 0 while out_valid=0
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEG_W  = DEF_SEG_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    input  logic              in_acc,
    input  logic              in_last,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int N_SEG  = DATA_W / SEG_W;
    localparam int SCNT_W = clog2(SEG_W + 1);
    localparam int CNT_W  = clog2(DATA_W + 1);
    localparam int SUM_W  = ACC_W + 1;

    if (DATA_W % SEG_W != 0) begin : g_bad_seg_w
        $error("popcount_stream: DATA_W must be a multiple of SEG_W");
    end
    if (ACC_W < CNT_W) begin : g_bad_acc_w
        $error("popcount_stream: ACC_W too narrow to hold one beat count");
    end

    // ---------------------------------------------------------------
    // Stage 1: per-segment counts
    // ---------------------------------------------------------------
    // Counting zeros is counting ones of the inverted word, so the segment
    // counters are shared between both modes.
    logic [DATA_W-1:0] word;
    logic [SCNT_W-1:0] seg_cnt [N_SEG];

    assign word = in_data ^ {DATA_W{in_mode}};

    for (genvar g = 0; g < N_SEG; g++) begin : g_seg
        seg_popcount #(
            .SEG_W (SEG_W)
        ) u_seg (
            .seg (word[g*SEG_W +: SEG_W]),
            .cnt (seg_cnt[g])
        );
    end

    logic              s1_valid;
    logic              s1_acc;
    logic              s1_last;
    logic [SCNT_W-1:0] s1_cnt [N_SEG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_acc   <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < N_SEG; i++) begin
                s1_cnt[i] <= '0;
            end
        end else begin
            s1_valid <= in_valid;
            // Payload only loads on real beats so bubbles cause no toggling.
            if (in_valid) begin
                s1_acc  <= in_acc;
                s1_last <= in_last;
                for (int i = 0; i < N_SEG; i++) begin
                    s1_cnt[i] <= seg_cnt[i];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: beat count from the segment counts
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] beat_cnt;

    always_comb begin
        beat_cnt = '0;
        for (int i = 0; i < N_SEG; i++) begin
            beat_cnt = beat_cnt + CNT_W'(s1_cnt[i]);
        end
    end

    logic             s2_valid;
    logic             s2_acc;
    logic             s2_last;
    logic [CNT_W-1:0] s2_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_acc   <= 1'b0;
            s2_last  <= 1'b0;
            s2_cnt   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_acc  <= s1_acc;
                s2_last <= s1_last;
                s2_cnt  <= beat_cnt;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: result and packet accumulator
    // ---------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic             sat_flag;
    logic [SUM_W-1:0] acc_sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;
    logic [ACC_W-1:0] cnt_ext;

    // One extra sum bit catches overflow; the saturated value then sticks at
    // all-ones because any further non-negative add overflows again.
    assign acc_sum = {1'b0, acc} + SUM_W'(s2_cnt);
    assign sum_ovf = acc_sum[ACC_W];
    assign sum_sat = sum_ovf ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign cnt_ext = ACC_W'(s2_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            acc       <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            if (s2_valid) begin
                if (!s2_acc) begin
                    // Standalone beat: bypasses the accumulator entirely so it
                    // can be interleaved inside an open packet.
                    out_valid <= 1'b1;
                    out_data  <= cnt_ext;
                end else if (s2_last) begin
                    out_valid <= 1'b1;
                    out_data  <= sum_sat;
                    out_sat   <= sat_flag | sum_ovf;
                    acc       <= '0;
                    sat_flag  <= 1'b0;
                end else begin
                    acc      <= sum_sat;
                    sat_flag <= sat_flag | sum_ovf;
                end
            end
        end
    end

endmodule
